// File: rtl/maze_move_executor.sv
// Environment-side move executor for the maze agent: validates a requested move against
// the grid and blocked cells, holds a timed travel window, then reports the new cell.
module maze_move_executor #(
    parameter int unsigned GRID_W      = 6,
    parameter int unsigned GRID_H      = 6,
    parameter int unsigned N_BLOCKED   = 16,
    parameter int unsigned MOVE_CYCLES = 50000,
    parameter int unsigned BUMP_CYCLES = 5000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        timer_start,
    input  logic [5:0]                  next_state,
    input  logic                        load_start,
    input  logic [5:0]                  start_state,
    input  logic [N_BLOCKED-1:0][5:0]   blocked,
    input  logic [5:0]                  target_state,
    output logic [5:0]                  maze_state,
    output logic                        move_complete,
    output logic                        bump,
    output logic                        target_reached,
    output logic [15:0]                 move_count
);

    localparam int unsigned SW        = 6;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned N_CELLS   = GRID_W * GRID_H;
    localparam int unsigned MAX_CYC   = (MOVE_CYCLES > BUMP_CYCLES) ? MOVE_CYCLES : BUMP_CYCLES;
    localparam int unsigned CW        = $clog2(MAX_CYC);
    localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] BUMP_LOAD = CW'(BUMP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_MOVING = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_req;
    logic              r_legal;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_maze_state;
    logic              r_move_complete;
    logic              r_bump;
    logic              r_target_reached;
    logic [CNT_W-1:0]  r_move_count;

    logic [SW-1:0]     w_req_nxt;
    logic              w_legal_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [SW-1:0]     w_maze_state_nxt;
    logic              w_move_complete_nxt;
    logic              w_bump_nxt;
    logic              w_target_reached_nxt;
    logic [CNT_W-1:0]  w_move_count_nxt;

    logic [SW-1:0]     w_req_row;
    logic [SW-1:0]     w_req_col;
    logic [SW-1:0]     w_cur_row;
    logic [SW-1:0]     w_cur_col;
    logic              w_in_range;
    logic              w_adjacent;
    logic              w_hit;
    logic              w_legal;

    // Move legality: on-grid, 4-neighbour without row wrap, and not a blocked cell
    assign w_req_row  = r_req / SW'(GRID_W);
    assign w_req_col  = r_req % SW'(GRID_W);
    assign w_cur_row  = r_maze_state / SW'(GRID_W);
    assign w_cur_col  = r_maze_state % SW'(GRID_W);
    assign w_in_range = (r_req < SW'(N_CELLS));
    assign w_adjacent = ((w_req_row == w_cur_row) &&
                         ((w_req_col == w_cur_col + SW'(1)) || (w_cur_col == w_req_col + SW'(1)))) ||
                        ((w_req_col == w_cur_col) &&
                         ((w_req_row == w_cur_row + SW'(1)) || (w_cur_row == w_req_row + SW'(1))));

    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < N_BLOCKED; i++) begin
            if (blocked[i] == r_req) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_legal = w_in_range && w_adjacent && !w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!load_start && timer_start) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = S_MOVING;
            S_MOVING: if (r_cnt == '0) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for every registered output and datapath register
    always_comb begin
        w_req_nxt            = r_req;
        w_legal_nxt          = r_legal;
        w_cnt_nxt            = r_cnt;
        w_maze_state_nxt     = r_maze_state;
        w_move_complete_nxt  = r_move_complete;
        w_bump_nxt           = 1'b0;
        w_target_reached_nxt = (r_maze_state == target_state);
        w_move_count_nxt     = r_move_count;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    if (start_state < SW'(N_CELLS)) begin
                        w_maze_state_nxt = start_state;
                        w_move_count_nxt = '0;
                    end
                end else if (timer_start) begin
                    w_req_nxt           = next_state;
                    w_move_complete_nxt = 1'b0;
                end
            end
            S_CHECK: begin
                w_legal_nxt = w_legal;
                w_cnt_nxt   = w_legal ? MOVE_LOAD : BUMP_LOAD;
            end
            S_MOVING: begin
                if (r_cnt == '0) begin
                    w_move_complete_nxt = 1'b1;
                    if (r_legal) begin
                        w_maze_state_nxt = r_req;
                        if (r_move_count != {CNT_W{1'b1}}) begin
                            w_move_count_nxt = r_move_count + CNT_W'(1);
                        end
                    end else begin
                        w_bump_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req            <= '0;
            r_legal          <= 1'b0;
            r_cnt            <= '0;
            r_maze_state     <= '0;
            r_move_complete  <= 1'b1;
            r_bump           <= 1'b0;
            r_target_reached <= 1'b0;
            r_move_count     <= '0;
        end else begin
            r_req            <= w_req_nxt;
            r_legal          <= w_legal_nxt;
            r_cnt            <= w_cnt_nxt;
            r_maze_state     <= w_maze_state_nxt;
            r_move_complete  <= w_move_complete_nxt;
            r_bump           <= w_bump_nxt;
            r_target_reached <= w_target_reached_nxt;
            r_move_count     <= w_move_count_nxt;
        end
    end

    assign maze_state     = r_maze_state;
    assign move_complete  = r_move_complete;
    assign bump           = r_bump;
    assign target_reached = r_target_reached;
    assign move_count     = r_move_count;

endmodule

// File: tb/tb_maze_move_executor.sv
// Bench for maze_move_executor: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level maze model.
module tb_maze_move_executor;

    localparam int MOVE_C = 4;
    localparam int BUMP_C = 2;
    localparam int NB     = 16;
    localparam int CELLS  = 36;

    logic                clk;
    logic                rst;
    logic                timer_start;
    logic [5:0]          next_state;
    logic                load_start;
    logic [5:0]          start_state;
    logic [NB-1:0][5:0]  blocked;
    logic [5:0]          target_state;
    logic [5:0]          maze_state;
    logic                move_complete;
    logic                bump;
    logic                target_reached;
    logic [15:0]         move_count;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    maze_move_executor #(
        .GRID_W(6), .GRID_H(6), .N_BLOCKED(NB),
        .MOVE_CYCLES(MOVE_C), .BUMP_CYCLES(BUMP_C)
    ) dut (
        .clk(clk), .rst(rst),
        .timer_start(timer_start), .next_state(next_state),
        .load_start(load_start), .start_state(start_state),
        .blocked(blocked), .target_state(target_state),
        .maze_state(maze_state), .move_complete(move_complete),
        .bump(bump), .target_reached(target_reached),
        .move_count(move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Grid rules: on-grid, Manhattan distance exactly 1 in row/col space, not blocked
    function automatic bit legal_move(input int cur, input int dst);
        int dr, dc;
        if (dst >= CELLS) return 1'b0;
        dr = dst / 6 - cur / 6;
        dc = dst % 6 - cur % 6;
        if (((dr < 0) ? -dr : dr) + ((dc < 0) ? -dc : dc) != 1) return 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (int'(blocked[i]) == dst) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Transaction model: a move occupies a fixed window of cycles, then resolves
    int m_cell, m_count, m_busy, m_dst;
    bit m_legal, m_bump, m_tr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cell  <= 0;
            m_count <= 0;
            m_busy  <= 0;
            m_dst   <= 0;
            m_legal <= 1'b0;
            m_bump  <= 1'b0;
            m_tr    <= 1'b0;
        end else begin
            m_tr   <= (m_cell == int'(target_state));
            m_bump <= 1'b0;
            if (m_busy == 0) begin
                if (load_start) begin
                    if (int'(start_state) < CELLS) begin
                        m_cell  <= int'(start_state);
                        m_count <= 0;
                    end
                end else if (timer_start) begin
                    m_legal <= legal_move(m_cell, int'(next_state));
                    m_dst   <= int'(next_state);
                    m_busy  <= legal_move(m_cell, int'(next_state)) ? MOVE_C + 1 : BUMP_C + 1;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    if (m_legal) begin
                        m_cell <= m_dst;
                        if (m_count != 65535) m_count <= m_count + 1;
                    end else begin
                        m_bump <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_maze_state", int'(maze_state), m_cell);
            chk("cyc_move_complete", int'(move_complete), int'(m_busy == 0));
            chk("cyc_bump", int'(bump), int'(m_bump));
            chk("cyc_target_reached", int'(target_reached), int'(m_tr));
            chk("cyc_move_count", int'(move_count), m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s);
        tick();
        load_start  = 1'b1;
        start_state = 6'(s);
        tick();
        load_start  = 1'b0;
    endtask

    // Issue one move and observe a fixed window; optionally pulse timer_start mid-move
    task automatic do_move(input int dst, input bit mid_pulse, output int low, output int bumps,
                           output int comps, output int tra, output int trn);
        int  arr;
        int  prev_ms;
        bit  prev_mc;
        low = 0; bumps = 0; comps = 0; tra = -1; trn = -1; arr = -1;
        tick();
        prev_ms     = int'(maze_state);
        prev_mc     = move_complete;
        next_state  = 6'(dst);
        timer_start = 1'b1;
        tick();
        timer_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!move_complete) low++;
            if (bump) bumps++;
            if (move_complete && !prev_mc) comps++;
            if (arr < 0 && int'(maze_state) == dst && prev_ms != dst) begin
                arr = i;
                tra = int'(target_reached);
            end else if (arr >= 0 && i == arr + 1) begin
                trn = int'(target_reached);
            end
            prev_mc = move_complete;
            prev_ms = int'(maze_state);
            if (mid_pulse && i == 2) timer_start = 1'b1;
            if (i == 3) timer_start = 1'b0;
        end
    endtask

    initial begin
        int low, bumps, comps, tra, trn, hold, r, dir, nb;
        rst          = 1'b0;
        timer_start  = 1'b0;
        load_start   = 1'b0;
        next_state   = '0;
        start_state  = '0;
        target_state = 6'd35;
        for (int i = 0; i < NB; i++) blocked[i] = 6'd63;
        blocked[0] = 6'd8;

        repeat (3) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_maze_state", int'(maze_state), 0);
        chk("reset_move_complete", int'(move_complete), 1);
        chk("reset_move_count", int'(move_count), 0);
        chk("reset_bump", int'(bump), 0);
        tick();
        rst = 1'b1;

        load(7);
        @(negedge clk);
        chk("load_maze_state", int'(maze_state), 7);
        chk("load_move_complete", int'(move_complete), 1);

        do_move(13, 1'b0, low, bumps, comps, tra, trn);
        chk("legal_low_cycles", low, MOVE_C + 1);
        chk("legal_maze_state", int'(maze_state), 13);
        chk("legal_move_count", int'(move_count), 1);
        chk("legal_bumps", bumps, 0);

        load(7);
        do_move(8, 1'b0, low, bumps, comps, tra, trn);
        chk("blocked_low_cycles", low, BUMP_C + 1);
        chk("blocked_bumps", bumps, 1);
        chk("blocked_maze_state", int'(maze_state), 7);

        load(5);
        do_move(6, 1'b0, low, bumps, comps, tra, trn);
        chk("wrap_bumps", bumps, 1);
        chk("wrap_maze_state", int'(maze_state), 5);

        load(7);
        do_move(13, 1'b0, low, bumps, comps, tra, trn);
        do_move(7, 1'b0, low, bumps, comps, tra, trn);
        do_move(40, 1'b0, low, bumps, comps, tra, trn);
        chk("offgrid_bumps", bumps, 1);
        chk("offgrid_maze_state", int'(maze_state), 7);
        chk("offgrid_move_count", int'(move_count), 2);
        do_move(7, 1'b0, low, bumps, comps, tra, trn);
        chk("self_move_bumps", bumps, 1);

        target_state = 6'd14;
        load(13);
        do_move(14, 1'b1, low, bumps, comps, tra, trn);
        chk("target_completions", comps, 1);
        chk("target_maze_state", int'(maze_state), 14);
        chk("target_at_arrival", tra, 0);
        chk("target_next_cycle", trn, 1);

        load(7);
        tick();
        next_state  = 6'd13;
        timer_start = 1'b1;
        tick();
        timer_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_maze_state", int'(maze_state), 0);
        chk("abort_move_complete", int'(move_complete), 1);
        chk("abort_move_count", int'(move_count), 0);
        chk("abort_bump", int'(bump), 0);
        tick();
        rst = 1'b1;
        do_move(1, 1'b0, low, bumps, comps, tra, trn);
        chk("post_abort_low_cycles", low, MOVE_C + 1);
        chk("post_abort_maze_state", int'(maze_state), 1);

        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (cyc % 400 == 399) begin
                timer_start = 1'b0;
                load_start  = 1'b0;
                hold        = 0;
                tick();
                tick();
                for (int i = 0; i < NB; i++)
                    blocked[i] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 35)) : 6'd63;
            end else begin
                load_start  = ($urandom_range(0, 24) == 0);
                start_state = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(36, 63))
                                                          : 6'($urandom_range(0, 35));
                if (hold > 0) begin
                    hold--;
                end else if ($urandom_range(0, 29) == 0) begin
                    hold        = $urandom_range(5, 20);
                    timer_start = 1'b1;
                end else begin
                    timer_start = ($urandom_range(0, 2) == 0);
                end
                r = $urandom_range(0, 9);
                if (r < 7) begin
                    dir = $urandom_range(0, 3);
                    case (dir)
                        0:       nb = m_cell - 1;
                        1:       nb = m_cell + 1;
                        2:       nb = m_cell - 6;
                        default: nb = m_cell + 6;
                    endcase
                    next_state = 6'(nb & 63);
                end else if (r == 7) begin
                    next_state = 6'(m_cell);
                end else begin
                    next_state = 6'($urandom_range(0, 63));
                end
                if ($urandom_range(0, 49) == 0) target_state = 6'($urandom_range(0, 35));
            end
        end
        timer_start = 1'b0;
        load_start  = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/maze_move_executor.md
Name: maze_move_executor

Overview:
- Environment-side responder to the Q-learning agent's move interface.
- Accepts a requested move (next_state + timer_start pulse) and checks it against the 6x6 grid and the blocked-cell list.
- Holds a timed move window standing in for physical robot travel, then returns the resulting maze_state with move_complete high.
- Sits between the agent and the motor/display logic; also used standalone to close the loop in simulation.

Parameters:
- GRID_W, 6, grid columns; state = row*GRID_W + col.
- GRID_H, 6, grid rows; legal states 0..GRID_W*GRID_H-1 (0..35).
- N_BLOCKED, 16, number of blocked-cell entries.
- MOVE_CYCLES, 50000, clocks for a legal move (1 ms at 50 MHz); minimum 2.
- BUMP_CYCLES, 5000, clocks for a rejected move; minimum 2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- timer_start  in  1  move request strobe from agent; sampled only in IDLE
- next_state  in  6  requested destination state, sampled with timer_start
- load_start  in  1  pulse: place agent at start_state (IDLE only)
- start_state  in  6  start cell
- blocked  in  6 x N_BLOCKED  blocked cell list; entries >= 36 never match
- target_state  in  6  goal cell
- maze_state  out  6  current agent cell
- move_complete  out  1  high = idle/ready; low while a move is in progress
- bump  out  1  one-cycle pulse when a rejected move completes
- target_reached  out  1  registered: maze_state == target_state
- move_count  out  16  legal moves completed since load_start; saturates at 0xFFFF

Behaviour:
- Reset (rst low, async): state IDLE, maze_state=0, move_complete=1, bump=0, target_reached=0, move_count=0, counter=0.
- FSM states are IDLE, CHECK and MOVING.
- IDLE, load_start=1:
  - If start_state<36: maze_state<=start_state, move_count<=0. Otherwise ignored.
  - load_start wins over a simultaneous timer_start; that timer_start is dropped.
- IDLE, timer_start=1 (at edge N):
  - Latch next_state into req.
  - move_complete<=0; go to CHECK.
- CHECK (edge N+1): legal iff all of the following hold:
  - req<36;
  - req adjacent to maze_state: same row with column difference 1, or same column with row difference 1. No wrap across row ends, so 5->6 is illegal.
  - req matches no blocked entry; blocked is sampled at this edge.
  - Then load counter with MOVE_CYCLES-1 (legal) or BUMP_CYCLES-1 (illegal), latch the legal flag, go to MOVING.
- MOVING:
  - Counter decrements each clock.
  - At the edge where counter==0: go to IDLE and set move_complete<=1.
  - Legal move: maze_state<=req and move_count increments (saturating).
  - Illegal move: maze_state unchanged and bump<=1 for one cycle.
- Latency: timer_start sampled at edge N gives move_complete high after edge N+MOVE_CYCLES+1 (legal) or N+BUMP_CYCLES+1 (illegal). move_complete is low for exactly MOVE_CYCLES+1 / BUMP_CYCLES+1 cycles.
- target_reached is registered every clock from the registered maze_state compare, so it lags maze_state by one cycle.
- timer_start or load_start outside IDLE is ignored; there is no queueing.
- A request equal to the current state is illegal (bump).
- A timer_start held high continuously in IDLE starts a new move on the first IDLE cycle after completion.
- Reset asserted mid-move aborts immediately to reset values. The partial move is lost and no bump is issued.
- Counter width is clog2(max(MOVE_CYCLES, BUMP_CYCLES)).

Test Plan (MOVE_CYCLES=4, BUMP_CYCLES=2, blocked all 63 except blocked[0]=8):
- Release reset, pulse load_start with start_state=7 -> maze_state=7, move_complete=1, move_count=0.
- timer_start with next_state=13 -> move_complete low 5 cycles, then maze_state=13, move_count=1, bump=0.
- From 7, next_state=8 (blocked) -> move_complete low 3 cycles, maze_state=7, bump single-cycle pulse.
- From 5, next_state=6 (row wrap), and from 7, next_state=40 -> both bump, maze_state unchanged, move_count unchanged.
- target_state=14, move 13->14 -> target_reached=1 one cycle after maze_state=14. A timer_start pulsed mid-move is ignored: exactly one completion.
- Drop rst for one cycle during MOVING -> immediate maze_state=0, move_complete=1, move_count=0, no bump. The next timer_start is accepted normally.
